// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 bus emulator.
// Frame FSM encoding, output-format selectors and the neutral chroma byte.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    localparam logic [2:0] MODE_RGB444 = 3'b000;
    localparam logic [2:0] MODE_RGB555 = 3'b001;
    localparam logic [2:0] MODE_RGB565 = 3'b010;
    localparam logic [2:0] MODE_YUV    = 3'b011;

    localparam logic [7:0] CHROMA_MID = 8'h80;

endpackage

// File: rtl/ov7670_pxl_enc.sv
// RGB332 / gray pixel to OV7670 two-byte word.
// Bit placement lets the capture side rebuild the original byte exactly.
module ov7670_pxl_enc
    import ov7670_pkg::*;
(
    input  logic [2:0] mode,
    input  logic [7:0] pxl,
    output logic [7:0] byte0,
    output logic [7:0] byte1
);

    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;

    assign r = pxl[7:5];
    assign g = pxl[4:2];
    assign b = pxl[1:0];

    always_comb begin
        byte0 = CHROMA_MID;
        byte1 = pxl;
        unique case (1'b1)
            (mode == MODE_RGB444): begin
                byte0 = {4'h0, r, 1'b0};
                byte1 = {g, 1'b0, b, 2'b00};
            end
            (mode == MODE_RGB555): begin
                byte0 = {1'b0, r, 2'b00, g[2:1]};
                byte1 = {g[0], 2'b00, b, 3'b000};
            end
            (mode == MODE_RGB565): begin
                byte0 = {r, 2'b00, g};
                byte1 = {3'b000, b, 3'b000};
            end
            (mode == MODE_YUV): begin
                byte0 = pxl;
                byte1 = CHROMA_MID;
            end
            default: begin
                byte0 = CHROMA_MID;
                byte1 = pxl;
            end
        endcase
    end

endmodule

// File: rtl/ov7670_emu_tx.sv
// OV7670-style pixel bus transmitter fed from a frame buffer.
// All bus outputs change on the clk edge where pclk rises.
module ov7670_emu_tx
    import ov7670_pkg::*;
#(
    parameter int c_img_cols     = 640,
    parameter int c_img_rows     = 480,
    parameter int c_nb_img_pxls  = 19,
    parameter int c_pclk_half    = 2,
    parameter int c_hblank_pclk  = 288,
    parameter int c_vsync_lines  = 3,
    parameter int c_vback_lines  = 17,
    parameter int c_vfront_lines = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               sw13_rgbmode,
    output logic [c_nb_img_pxls-1:0] fb_addr,
    input  logic [7:0]               fb_data,
    output logic                     pclk,
    output logic                     href,
    output logic                     vsync,
    output logic [7:0]               data,
    output logic                     frame_done
);

    localparam int LINE = 2 * c_img_cols + c_hblank_pclk;
    localparam int DW   = (c_pclk_half > 1) ? $clog2(c_pclk_half) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(c_pclk_half - 1);
    localparam logic [15:0]   H_LAST   = 16'(LINE - 1);
    localparam logic [15:0]   H_ACT    = 16'(2 * c_img_cols);

    localparam logic [c_nb_img_pxls-1:0] ADDR_LAST =
        c_nb_img_pxls'(c_img_cols * c_img_rows - 1);

    state_t        state;
    state_t        nxt_state;
    logic [DW-1:0] div;
    logic [15:0]   hcnt;
    logic [15:0]   vcnt;
    logic [15:0]   nxt_h;
    logic [15:0]   nxt_v;
    logic [15:0]   v_last;
    logic [2:0]    mode;
    logic [7:0]    byte1_q;
    logic [7:0]    enc_b0;
    logic [7:0]    enc_b1;
    logic          rise;
    logic          frame_end;
    logic          nxt_href;
    logic          nxt_byte0;

    ov7670_pxl_enc u_enc (
        .mode  (mode),
        .pxl   (fb_data),
        .byte0 (enc_b0),
        .byte1 (enc_b1)
    );

    assign rise = !pclk && (div == DIV_LAST);

    always_comb begin
        v_last = '0;
        unique case (state)
            ST_VSYNC:  v_last = 16'(c_vsync_lines - 1);
            ST_VBACK:  v_last = 16'(c_vback_lines - 1);
            ST_ACTIVE: v_last = 16'(c_img_rows - 1);
            ST_VFRONT: v_last = 16'(c_vfront_lines - 1);
            default:   v_last = '0;
        endcase
    end

    // Position of the pclk period that starts at the next rise.
    always_comb begin
        nxt_state = state;
        nxt_h     = hcnt + 16'd1;
        nxt_v     = vcnt;
        frame_end = 1'b0;
        if (state == ST_IDLE) begin
            nxt_h = '0;
            nxt_v = '0;
            if (en) nxt_state = ST_VSYNC;
        end else if (hcnt == H_LAST) begin
            nxt_h = '0;
            nxt_v = vcnt + 16'd1;
            if (vcnt == v_last) begin
                nxt_v = '0;
                unique case (state)
                    ST_VSYNC:  nxt_state = ST_VBACK;
                    ST_VBACK:  nxt_state = ST_ACTIVE;
                    ST_ACTIVE: nxt_state = ST_VFRONT;
                    ST_VFRONT: begin
                        frame_end = 1'b1;
                        nxt_state = en ? ST_VSYNC : ST_IDLE;
                    end
                    default:   nxt_state = ST_IDLE;
                endcase
            end
        end
    end

    assign nxt_href  = (nxt_state == ST_ACTIVE) && (nxt_h < H_ACT);
    assign nxt_byte0 = nxt_href && !nxt_h[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            div        <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
            mode       <= '0;
            byte1_q    <= '0;
            fb_addr    <= '0;
            pclk       <= 1'b0;
            href       <= 1'b0;
            vsync      <= 1'b0;
            data       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (div == DIV_LAST) begin
                div  <= '0;
                pclk <= !pclk;
            end else begin
                div <= div + 1'b1;
            end
            if (rise) begin
                state      <= nxt_state;
                hcnt       <= nxt_h;
                vcnt       <= nxt_v;
                href       <= nxt_href;
                vsync      <= (nxt_state == ST_VSYNC);
                frame_done <= frame_end;
                data       <= '0;
                // fb_data for this pixel is valid now; keep byte1 for later
                if (nxt_byte0) begin
                    data    <= enc_b0;
                    byte1_q <= enc_b1;
                    if (fb_addr != ADDR_LAST) fb_addr <= fb_addr + 1'b1;
                end else if (nxt_href) begin
                    data <= byte1_q;
                end
                if (nxt_state == ST_VSYNC && state != ST_VSYNC) begin
                    fb_addr <= '0;
                    mode    <= sw13_rgbmode;
                end
            end
        end
    end

endmodule
